// File: rtl/rv32_pkg.sv
// Shared RV32I decode types: ALU/branch/memory-size codes, opcodes and the decoded control bundle.
// Imported by the decode stage and by execute.
package rv32_pkg;

    typedef enum logic [4:0] {
        FOP_ADD    = 5'd0,
        FOP_SUB    = 5'd1,
        FOP_SLL    = 5'd2,
        FOP_SRL    = 5'd3,
        FOP_SRA    = 5'd4,
        FOP_AND    = 5'd5,
        FOP_OR     = 5'd6,
        FOP_XOR    = 5'd7,
        FOP_IMM    = 5'd8,
        FOP_SLT    = 5'd9,
        FOP_SLTU   = 5'd10,
        FOP_MUL    = 5'd11,
        FOP_MULH   = 5'd12,
        FOP_MULHSU = 5'd13,
        FOP_MULHU  = 5'd14,
        FOP_DIV    = 5'd15,
        FOP_DIVU   = 5'd16,
        FOP_REM    = 5'd17,
        FOP_REMU   = 5'd18
    } fop_t;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLT  = 3'd3,
        BR_BGE  = 3'd4,
        BR_BLTU = 3'd5,
        BR_BGEU = 3'd6
    } b_t;

    typedef enum logic [1:0] {
        MS_BYTE = 2'd0,
        MS_HALF = 2'd1,
        MS_WORD = 2'd2
    } mem_size_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        fop_t        alu_op;
        b_t          branch_type;
        mem_size_t   mem_size;
        logic        mem_unsigned;
        logic        reg_write_en;
        logic        alu_src_imm;
        logic        mem_to_reg;
        logic        read_mem;
        logic        write_mem;
        logic        jump_abs;
        logic        link_pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        illegal;
    } bundle_t;

endpackage

// File: rtl/rv32_decode_stage_if.sv
// Fetch-side and execute-side handshake plus decoded control outputs of the decode stage.
// master = surrounding pipeline (fetch/execute), slave = the decode stage.
interface rv32_decode_stage_if #(parameter int PC_W = 32);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      alu_op;
    logic [2:0]      branch_type;
    logic [1:0]      mem_size;
    logic            mem_unsigned;
    logic            reg_write_en;
    logic            alu_src_imm;
    logic            mem_to_reg;
    logic            read_mem;
    logic            write_mem;
    logic            jump_abs;
    logic            link_pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [31:0]     imm;
    logic [PC_W-1:0] pc_out;
    logic            illegal;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, alu_op, branch_type, mem_size, mem_unsigned,
               reg_write_en, alu_src_imm, mem_to_reg, read_mem, write_mem,
               jump_abs, link_pc, rd, rs1, rs2, imm, pc_out, illegal
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, alu_op, branch_type, mem_size, mem_unsigned,
               reg_write_en, alu_src_imm, mem_to_reg, read_mem, write_mem,
               jump_abs, link_pc, rd, rs1, rs2, imm, pc_out, illegal
    );
endinterface

// File: rtl/rv32_decoder.sv
// Combinational RV32I decoder: instruction word to control bundle, zero latency, no handshake.
// RV32_DECODE_MULDIV_EN enables the RV32M encodings; otherwise they decode as illegal.
module rv32_decoder
    import rv32_pkg::*;
(
    input  logic [31:0] instr,
    output bundle_t     bundle
);

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [4:0]  f_rd, f_rs1, f_rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    logic        ok;
    bundle_t     b;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign f_rd   = instr[11:7];
    assign f_rs1  = instr[19:15];
    assign f_rs2  = instr[24:20];

    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_sh = {27'b0, instr[24:20]};

    // Register index fields are only reported for the operands the format actually has.
    always_comb begin
        b  = '0;
        ok = 1'b1;
        case (opcode)
            OPC_LUI: begin
                b.alu_op = FOP_IMM; b.reg_write_en = 1'b1; b.alu_src_imm = 1'b1;
                b.rd = f_rd; b.imm = imm_u;
            end
            OPC_AUIPC: begin
                b.alu_op = FOP_ADD; b.reg_write_en = 1'b1; b.alu_src_imm = 1'b1;
                b.rd = f_rd; b.imm = imm_u;
            end
            OPC_JAL: begin
                b.alu_op = FOP_ADD; b.reg_write_en = 1'b1; b.alu_src_imm = 1'b1;
                b.link_pc = 1'b1; b.rd = f_rd; b.imm = imm_j;
            end
            OPC_JALR: begin
                ok = (funct3 == 3'b000);
                b.alu_op = FOP_ADD; b.reg_write_en = 1'b1; b.alu_src_imm = 1'b1;
                b.link_pc = 1'b1; b.jump_abs = 1'b1;
                b.rd = f_rd; b.rs1 = f_rs1; b.imm = imm_i;
            end
            OPC_BRANCH: begin
                b.alu_op = FOP_SUB; b.rs1 = f_rs1; b.rs2 = f_rs2; b.imm = imm_b;
                case (funct3)
                    3'b000:  b.branch_type = BR_BEQ;
                    3'b001:  b.branch_type = BR_BNE;
                    3'b100:  b.branch_type = BR_BLT;
                    3'b101:  b.branch_type = BR_BGE;
                    3'b110:  b.branch_type = BR_BLTU;
                    3'b111:  b.branch_type = BR_BGEU;
                    default: ok = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                b.alu_op = FOP_ADD; b.reg_write_en = 1'b1; b.alu_src_imm = 1'b1;
                b.mem_to_reg = 1'b1; b.read_mem = 1'b1;
                b.rd = f_rd; b.rs1 = f_rs1; b.imm = imm_i;
                case (funct3)
                    3'b000:  b.mem_size = MS_BYTE;
                    3'b001:  b.mem_size = MS_HALF;
                    3'b010:  b.mem_size = MS_WORD;
                    3'b100:  begin b.mem_size = MS_BYTE; b.mem_unsigned = 1'b1; end
                    3'b101:  begin b.mem_size = MS_HALF; b.mem_unsigned = 1'b1; end
                    default: ok = 1'b0;
                endcase
            end
            OPC_STORE: begin
                b.alu_op = FOP_ADD; b.alu_src_imm = 1'b1; b.write_mem = 1'b1;
                b.rs1 = f_rs1; b.rs2 = f_rs2; b.imm = imm_s;
                case (funct3)
                    3'b000:  b.mem_size = MS_BYTE;
                    3'b001:  b.mem_size = MS_HALF;
                    3'b010:  b.mem_size = MS_WORD;
                    default: ok = 1'b0;
                endcase
            end
            OPC_OPIMM: begin
                b.reg_write_en = 1'b1; b.alu_src_imm = 1'b1;
                b.rd = f_rd; b.rs1 = f_rs1; b.imm = imm_i;
                case (funct3)
                    3'b000: b.alu_op = FOP_ADD;
                    3'b010: b.alu_op = FOP_SLT;
                    3'b011: b.alu_op = FOP_SLTU;
                    3'b100: b.alu_op = FOP_XOR;
                    3'b110: b.alu_op = FOP_OR;
                    3'b111: b.alu_op = FOP_AND;
                    3'b001: begin
                        b.alu_op = FOP_SLL; b.imm = imm_sh;
                        ok = (funct7 == 7'b0000000);
                    end
                    3'b101: begin
                        b.imm = imm_sh;
                        if (funct7 == 7'b0000000)      b.alu_op = FOP_SRL;
                        else if (funct7 == 7'b0100000) b.alu_op = FOP_SRA;
                        else                           ok = 1'b0;
                    end
                endcase
            end
            OPC_OP: begin
                b.reg_write_en = 1'b1; b.rd = f_rd; b.rs1 = f_rs1; b.rs2 = f_rs2;
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000: b.alu_op = FOP_ADD;
                            3'b001: b.alu_op = FOP_SLL;
                            3'b010: b.alu_op = FOP_SLT;
                            3'b011: b.alu_op = FOP_SLTU;
                            3'b100: b.alu_op = FOP_XOR;
                            3'b101: b.alu_op = FOP_SRL;
                            3'b110: b.alu_op = FOP_OR;
                            3'b111: b.alu_op = FOP_AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (funct3 == 3'b000)      b.alu_op = FOP_SUB;
                        else if (funct3 == 3'b101) b.alu_op = FOP_SRA;
                        else                       ok = 1'b0;
                    end
`ifdef RV32_DECODE_MULDIV_EN
                    7'b0000001: b.alu_op = fop_t'(5'd11 + {2'b00, funct3});
`endif
                    default: ok = 1'b0;
                endcase
            end
            default: ok = 1'b0;
        endcase

        if (!ok) begin
            b         = '0;
            b.illegal = 1'b1;
        end
    end

    assign bundle = b;

endmodule

// File: rtl/rv32_decode_stage.sv
// Decode stage: decoder + DEPTH-entry bundle FIFO + RUN/HALT trap FSM; 1-cycle in->out latency.
// in_ready = RUN && !full (no dependence on out_ready); HALT after an illegal push until flush/rst.
module rv32_decode_stage
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    rv32_decode_stage_if.slave bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [AW:0]     count;
    logic [0:0]      state;
    bundle_t         dec, head;
    bundle_t         mem    [DEPTH];
    logic [PC_W-1:0] pc_mem [DEPTH];
    logic            full, empty, in_ready, push, pop;

    rv32_decoder u_decoder (
        .instr  (bus.in_instr),
        .bundle (dec)
    );

    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign in_ready = (state == ST_RUN) && !full;
    assign push     = bus.in_valid && in_ready;
    assign pop      = !empty && bus.out_ready;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            state  <= ST_RUN;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i]    <= '0;
                pc_mem[i] <= '0;
            end
        end else if (bus.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            state  <= ST_RUN;
        end else begin
            if (push) begin
                mem[wr_ptr]    <= dec;
                pc_mem[wr_ptr] <= bus.in_pc;
                wr_ptr         <= wr_ptr + 1'b1;
                if (dec.illegal) state <= ST_HALT;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head entry cannot be overwritten while occupied, so outputs hold under backpressure.
    assign head = mem[rd_ptr];

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = !empty;
    assign bus.alu_op       = head.alu_op;
    assign bus.branch_type  = head.branch_type;
    assign bus.mem_size     = head.mem_size;
    assign bus.mem_unsigned = head.mem_unsigned;
    assign bus.reg_write_en = head.reg_write_en;
    assign bus.alu_src_imm  = head.alu_src_imm;
    assign bus.mem_to_reg   = head.mem_to_reg;
    assign bus.read_mem     = head.read_mem;
    assign bus.write_mem    = head.write_mem;
    assign bus.jump_abs     = head.jump_abs;
    assign bus.link_pc      = head.link_pc;
    assign bus.rd           = head.rd;
    assign bus.rs1          = head.rs1;
    assign bus.rs2          = head.rs2;
    assign bus.imm          = head.imm;
    assign bus.illegal      = head.illegal;
    assign bus.pc_out       = pc_mem[rd_ptr];

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Bench for rv32_decode_stage: instruction-level reference model + queue scoreboard, plus literal spot checks.
// Expectations for the RV32M encodings follow RV32_DECODE_MULDIV_EN.
module tb_rv32_decode_stage;

    localparam int DEPTH = 2;
    localparam int PC_W  = 32;

    typedef struct packed {
        logic [4:0]  alu_op;
        logic [2:0]  br;
        logic [1:0]  msz;
        logic        mu, rwe, asi, m2r, rdm, wrm, jabs, lpc;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv32_decode_stage_if #(.PC_W(PC_W)) bus ();

    rv32_decode_stage #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_vec = 0, n_err = 0, n_sent = 0, dut_pops = 0;
    bit   chk_en = 1'b0;
    bit   halt = 1'b0;
    exp_t q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference decode from the ISA tables; immediates via signed arithmetic shifts.
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
        exp_t e;
        int   s;
        bit   legal;
        logic [2:0] f3;
        logic [6:0] f7;
        int alu_tab[8] = '{0, 2, 9, 10, 7, 3, 6, 5};
        int br_tab[8]  = '{1, 2, 0, 0, 3, 4, 5, 6};
        s = $signed(i);
        f3 = i[14:12];
        f7 = i[31:25];
        e = '0;
        legal = 1'b1;
        case (i[6:0])
            7'h37: begin e.alu_op = 8; e.rwe = 1; e.asi = 1; e.rd = i[11:7]; e.imm = i & 32'hFFFFF000; end
            7'h17: begin e.alu_op = 0; e.rwe = 1; e.asi = 1; e.rd = i[11:7]; e.imm = i & 32'hFFFFF000; end
            7'h6F: begin
                e.rwe = 1; e.asi = 1; e.lpc = 1; e.rd = i[11:7];
                e.imm = (32'(s >>> 31) << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
            end
            7'h67: begin
                legal = (f3 == 0);
                e.rwe = 1; e.asi = 1; e.lpc = 1; e.jabs = 1; e.rd = i[11:7]; e.rs1 = i[19:15];
                e.imm = 32'(s >>> 20);
            end
            7'h63: begin
                legal = (br_tab[f3] != 0);
                e.alu_op = 1; e.br = 3'(br_tab[f3]); e.rs1 = i[19:15]; e.rs2 = i[24:20];
                e.imm = (32'(s >>> 31) << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
            end
            7'h03: begin
                legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                e.rwe = 1; e.asi = 1; e.m2r = 1; e.rdm = 1; e.msz = f3[1:0]; e.mu = f3[2];
                e.rd = i[11:7]; e.rs1 = i[19:15]; e.imm = 32'(s >>> 20);
            end
            7'h23: begin
                legal = (f3 < 3);
                e.asi = 1; e.wrm = 1; e.msz = f3[1:0]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
                e.imm = (32'(s >>> 25) << 5) | 32'(i[11:7]);
            end
            7'h13: begin
                e.rwe = 1; e.asi = 1; e.rd = i[11:7]; e.rs1 = i[19:15];
                e.alu_op = 5'(alu_tab[f3]);
                e.imm = 32'(s >>> 20);
                if (f3 == 1 || f3 == 5) begin
                    e.imm = 32'(i[24:20]);
                    if (f3 == 5 && f7 == 7'h20) e.alu_op = 4;
                    else legal = (f7 == 0);
                end
            end
            7'h33: begin
                e.rwe = 1; e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
                if (f7 == 0) e.alu_op = 5'(alu_tab[f3]);
                else if (f7 == 7'h20 && f3 == 0) e.alu_op = 1;
                else if (f7 == 7'h20 && f3 == 5) e.alu_op = 4;
`ifdef RV32_DECODE_MULDIV_EN
                else if (f7 == 1) e.alu_op = 5'(11 + f3);
`endif
                else legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            e = '0;
            e.ill = 1'b1;
        end
        e.pc = pc;
        return e;
    endfunction

    function automatic exp_t dut_bundle();
        exp_t d;
        d = '{bus.alu_op, bus.branch_type, bus.mem_size, bus.mem_unsigned, bus.reg_write_en,
              bus.alu_src_imm, bus.mem_to_reg, bus.read_mem, bus.write_mem, bus.jump_abs,
              bus.link_pc, bus.rd, bus.rs1, bus.rs2, bus.imm, bus.illegal, bus.pc_out};
        return d;
    endfunction

    // Model state advances on the same edge as the DUT; inputs are stable there.
    initial forever begin
        @(posedge clk);
        if (rst || bus.flush) begin
            q.delete();
            halt = 1'b0;
        end else begin
            bit   rdy;
            exp_t e;
            rdy = !halt && (q.size() < DEPTH);
            if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
            if (bus.in_valid && rdy) begin
                e = model(bus.in_instr, bus.in_pc);
                q.push_back(e);
                if (e.ill) halt = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("in_ready", 128'(bus.in_ready), 128'(!halt && (q.size() < DEPTH)));
            chk("out_valid", 128'(bus.out_valid), 128'(q.size() > 0));
            if (q.size() > 0) chk("bundle", 128'(dut_bundle()), 128'(q[0]));
            if (bus.out_valid && bus.out_ready && !bus.flush && !rst) dut_pops++;
        end
    end

    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        bus.in_pc    = pc;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (bus.in_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (ok) n_sent++;
        else begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: instr %h never accepted", ins);
        end
    endtask

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    logic [31:0] prog[14] = '{32'h123452B7, 32'h00001317, 32'h010000EF, 32'h00008067,
                              32'h0020A423, 32'hFE209F23, 32'h00615383, 32'h4034D413,
                              32'h40C58533, 32'hFFF13093, 32'h0020D463, 32'h00311093,
                              32'h0020F0B3, 32'h4020D0B3};

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        @(negedge clk);
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_alu_op", 128'(bus.alu_op), 128'(0));
        chk("rst_imm", 128'(bus.imm), 128'(0));
        chk("rst_pc_out", 128'(bus.pc_out), 128'(0));
        cycle();

        bus.out_ready = 1'b1;
        send(32'h002081B3, 32'h100);
        @(negedge clk);
        chk("add_valid", 128'(bus.out_valid), 128'(1));
        chk("add_alu_op", 128'(bus.alu_op), 128'(0));
        chk("add_regs", 128'({bus.rd, bus.rs1, bus.rs2}), 128'({5'd3, 5'd1, 5'd2}));
        chk("add_rwe", 128'(bus.reg_write_en), 128'(1));
        chk("add_pc", 128'(bus.pc_out), 128'(32'h100));
        cycle();

        send(32'hFFC08283, 32'h104);
        @(negedge clk);
        chk("lb_imm", 128'(bus.imm), 128'(32'hFFFFFFFC));
        chk("lb_size_uns", 128'({bus.mem_size, bus.mem_unsigned}), 128'(3'b000));
        chk("lb_ctrl", 128'({bus.read_mem, bus.mem_to_reg, bus.alu_src_imm}), 128'(3'b111));
        cycle();

        send(32'h0020E463, 32'h108);
        @(negedge clk);
        chk("bltu_type", 128'(bus.branch_type), 128'(5));
        chk("bltu_imm", 128'(bus.imm), 128'(8));
        chk("bltu_rwe", 128'(bus.reg_write_en), 128'(0));
        cycle();

        for (int k = 0; k < 14; k++) begin
            bus.out_ready = (k % 3 != 2);
            send(prog[k], 32'h200 + 32'(4 * k));
        end
        bus.out_ready = 1'b1;
        repeat (DEPTH + 2) cycle();

        // Backpressure: DEPTH accepted, then in_ready drops; extra entry goes in once drained.
        bus.out_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) send(32'h00A00093 + 32'(k << 7), 32'h300 + 32'(4 * k));
        @(negedge clk);
        chk("full_in_ready", 128'(bus.in_ready), 128'(0));
        chk("full_head_pc", 128'(bus.pc_out), 128'(32'h300));
        repeat (3) cycle();
        bus.out_ready = 1'b1;
        send(32'h00B00093, 32'h3F0);
        repeat (DEPTH + 2) cycle();
        @(negedge clk);
        chk("drained_valid", 128'(bus.out_valid), 128'(0));
        chk("pop_count", 128'(dut_pops), 128'(n_sent));
        cycle();

        // Illegal word halts fetch; FIFO still drains; flush beats a same-cycle input.
        bus.out_ready = 1'b0;
        send(32'h00000000, 32'h400);
        @(negedge clk);
        chk("ill_flag", 128'({bus.out_valid, bus.illegal}), 128'(2'b11));
        chk("ill_in_ready", 128'(bus.in_ready), 128'(0));
        cycle();
        bus.in_valid = 1'b1; bus.in_instr = 32'h002081B3; bus.in_pc = 32'h404;
        bus.out_ready = 1'b1;
        repeat (3) cycle();
        @(negedge clk);
        chk("halt_in_ready", 128'(bus.in_ready), 128'(0));
        chk("halt_drained", 128'(bus.out_valid), 128'(0));
        cycle();
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", 128'(bus.in_ready), 128'(1));
        chk("flush_empty", 128'(bus.out_valid), 128'(0));
        cycle();

        send(32'h022081B3, 32'h500);
        @(negedge clk);
`ifdef RV32_DECODE_MULDIV_EN
        chk("mul_alu_op", 128'({bus.alu_op, bus.reg_write_en, bus.illegal}), 128'({5'd11, 1'b1, 1'b0}));
`else
        chk("mul_illegal", 128'({bus.alu_op, bus.illegal}), 128'({5'd0, 1'b1}));
`endif
        cycle();
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;

        // Mid-stream reset clears the FIFO and zeroes the stored bundles.
        bus.out_ready = 1'b0;
        send(32'h0020A183, 32'h600);
        send(32'h40C58533, 32'h604);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_state", 128'({bus.out_valid, bus.in_ready}), 128'(2'b01));
        chk("rst2_zero", 128'({bus.alu_op, bus.imm, bus.pc_out}), 128'(0));
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
